// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit owning the architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one bit per i_step edge, then a sign-fixup cycle.
module ex_muldiv_unit #(
  parameter int unsigned BITS_SIZE = 32,
  parameter int unsigned BITS_CNT  = 6
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_step,
  input  logic                 i_start,
  input  logic [2:0]           i_op,
  input  logic [BITS_SIZE-1:0] i_rs_data,
  input  logic [BITS_SIZE-1:0] i_rt_data,
  output logic [BITS_SIZE-1:0] o_hi,
  output logic [BITS_SIZE-1:0] o_lo,
  output logic                 o_busy,
  output logic                 o_done
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_t;

  localparam logic [BITS_CNT-1:0] LAST_ITER = BITS_CNT'(BITS_SIZE - 1);

  state_t               state, state_nxt;
  op_t                  op;
  logic [BITS_CNT-1:0]  cnt;
  logic [BITS_SIZE-1:0] opnd;
  logic [BITS_SIZE-1:0] acc_hi;
  logic [BITS_SIZE-1:0] acc_lo;
  logic                 sign_q;
  logic                 sign_r;
  logic                 div_zero;
  logic                 is_div;

  logic                   op_signed;
  logic [BITS_SIZE-1:0]   a_mag;
  logic [BITS_SIZE-1:0]   b_mag;
  logic [BITS_SIZE:0]     mul_sum;
  logic [BITS_SIZE:0]     div_shift;
  logic [BITS_SIZE:0]     div_diff;
  logic [2*BITS_SIZE-1:0] prod_fix;
  logic [BITS_SIZE-1:0]   quo_fix;
  logic [BITS_SIZE-1:0]   rem_fix;

  assign op        = op_t'(i_op);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_mag     = (op_signed && i_rs_data[BITS_SIZE-1]) ? -i_rs_data : i_rs_data;
  assign b_mag     = (op_signed && i_rt_data[BITS_SIZE-1]) ? -i_rt_data : i_rt_data;

  // Multiplier sits in acc_lo and is consumed from the bottom as the product shifts in from the top.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

  // acc_hi is the partial remainder, acc_lo shifts the dividend out and the quotient in.
  assign div_shift = {acc_hi, acc_lo[BITS_SIZE-1]};
  assign div_diff  = div_shift - {1'b0, opnd};

  assign prod_fix  = sign_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign quo_fix   = sign_q ? -acc_lo : acc_lo;
  assign rem_fix   = sign_r ? -acc_hi : acc_hi;

  assign o_busy    = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state <= IDLE;
    end else if (i_step) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (i_start) begin
          if (op == OP_MULT || op == OP_MULTU) begin
            state_nxt = MUL;
          end else if (op == OP_DIV || op == OP_DIVU) begin
            state_nxt = DIV;
          end
        end
      end
      MUL, DIV: begin
        if (cnt == LAST_ITER) begin
          state_nxt = FIX;
        end
      end
      FIX: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      cnt      <= '0;
      o_hi     <= '0;
      o_lo     <= '0;
      o_done   <= 1'b0;
      opnd     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_zero <= 1'b0;
      is_div   <= 1'b0;
    end else if (i_step) begin
      o_done <= (state == FIX);
      unique case (state)
        IDLE: begin
          if (i_start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                opnd     <= a_mag;
                acc_hi   <= '0;
                acc_lo   <= b_mag;
                sign_q   <= op_signed && (i_rs_data[BITS_SIZE-1] ^ i_rt_data[BITS_SIZE-1]);
                sign_r   <= 1'b0;
                div_zero <= 1'b0;
                is_div   <= 1'b0;
                cnt      <= '0;
              end
              OP_DIV, OP_DIVU: begin
                opnd     <= b_mag;
                acc_hi   <= '0;
                acc_lo   <= a_mag;
                sign_q   <= op_signed && (i_rs_data[BITS_SIZE-1] ^ i_rt_data[BITS_SIZE-1]);
                sign_r   <= op_signed && i_rs_data[BITS_SIZE-1];
                div_zero <= (i_rt_data == '0);
                is_div   <= 1'b1;
                cnt      <= '0;
              end
              OP_MTHI: o_hi <= i_rs_data;
              OP_MTLO: o_lo <= i_rs_data;
              default: ;
            endcase
          end
        end
        MUL: begin
          {acc_hi, acc_lo} <= {mul_sum, acc_lo[BITS_SIZE-1:1]};
          cnt              <= cnt + 1'b1;
        end
        DIV: begin
          acc_hi <= div_diff[BITS_SIZE] ? div_shift[BITS_SIZE-1:0] : div_diff[BITS_SIZE-1:0];
          acc_lo <= {acc_lo[BITS_SIZE-2:0], ~div_diff[BITS_SIZE]};
          cnt    <= cnt + 1'b1;
        end
        FIX: begin
          if (is_div) begin
            // Divide by zero leaves |A| as remainder; re-applying the dividend sign restores A verbatim.
            o_lo <= div_zero ? '1 : quo_fix;
            o_hi <= rem_fix;
          end else begin
            {o_hi, o_lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed cases plus randomized ops against an arithmetic model.
module tb_ex_muldiv_unit;

  logic        i_clk;
  logic        i_reset;
  logic        i_step;
  logic        i_start;
  logic [2:0]  i_op;
  logic [31:0] i_rs_data;
  logic [31:0] i_rt_data;
  logic [31:0] o_hi;
  logic [31:0] o_lo;
  logic        o_busy;
  logic        o_done;

  int checks   = 0;
  int failures = 0;

  ex_muldiv_unit #(.BITS_SIZE(32), .BITS_CNT(6)) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_step   (i_step),
    .i_start  (i_start),
    .i_op     (i_op),
    .i_rs_data(i_rs_data),
    .i_rt_data(i_rt_data),
    .o_hi     (o_hi),
    .o_lo     (o_lo),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural result {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] res;
    res = '0;
    case (op)
      3'd0: begin
        sa  = $signed(a);
        sb  = $signed(b);
        res = 64'(sa * sb);
      end
      3'd1: res = {32'h0, a} * {32'h0, b};
      3'd2: begin
        if (b == 32'h0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          sa  = $signed(a);
          sb  = $signed(b);
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
        else            res = {a % b, a / b};
      end
      default: res = {o_hi, o_lo};
    endcase
    return res;
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h0000_0000;
      1:       v = 32'h0000_0001;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h8000_0000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int stall_at, input int stall_len, input bit inject);
    logic [63:0] exp;
    logic [63:0] old;
    int          busy_cycles;
    int          done_seen;
    int          hold_bad;
    exp         = model(op, a, b);
    old         = {o_hi, o_lo};
    busy_cycles = 0;
    done_seen   = 0;
    hold_bad    = 0;
    i_op      = op;
    i_rs_data = a;
    i_rt_data = b;
    i_start   = 1'b1;
    i_step    = 1'b1;
    tick();
    i_start = 1'b0;
    while (o_busy === 1'b1 && busy_cycles < 200) begin
      busy_cycles++;
      if ({o_hi, o_lo} !== old) hold_bad++;
      if (o_done !== 1'b0) done_seen++;
      i_step = !(stall_len > 0 && busy_cycles > stall_at && busy_cycles <= stall_at + stall_len);
      if (inject && (busy_cycles == 5 || busy_cycles == stall_at + 2)) begin
        i_start   = 1'b1;
        i_op      = (busy_cycles == 5) ? 3'b100 : 3'b011;
        i_rs_data = 32'hDEAD_BEEF;
        i_rt_data = 32'h0000_0003;
      end else begin
        i_start = 1'b0;
      end
      tick();
    end
    i_step  = 1'b1;
    i_start = 1'b0;
    check({tag, " busy_cycles"}, 64'(busy_cycles), 64'(33 + stall_len));
    check({tag, " hilo_held"}, 64'(hold_bad), 64'd0);
    check({tag, " early_done"}, 64'(done_seen), 64'd0);
    check({tag, " hilo"}, {o_hi, o_lo}, exp);
    check({tag, " done_pulse"}, 64'(o_done), 64'd1);
    tick();
    check({tag, " done_clear"}, 64'(o_done), 64'd0);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    logic [63:0] prev;

    i_reset   = 1'b0;
    i_step    = 1'b0;
    i_start   = 1'b0;
    i_op      = 3'b000;
    i_rs_data = '0;
    i_rt_data = '0;
    tick();
    tick();
    check("reset_hi", 64'(o_hi), 64'd0);
    check("reset_lo", 64'(o_lo), 64'd0);
    check("reset_busy", 64'(o_busy), 64'd0);
    check("reset_done", 64'(o_done), 64'd0);
    i_reset = 1'b1;
    i_step  = 1'b1;
    tick();

    run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0);
    check("multu_max_hi", 64'(o_hi), 64'hFFFF_FFFE);
    check("multu_max_lo", 64'(o_lo), 64'h0000_0001);
    run_op("mult_neg", 3'b000, 32'hFFFF_FFFD, 32'h0000_0007, 0, 0, 1'b0);
    check("mult_neg_lo", 64'(o_lo), 64'hFFFF_FFEB);
    run_op("mult_min", 3'b000, 32'h8000_0000, 32'h8000_0000, 0, 0, 1'b0);
    check("mult_min_hi", 64'(o_hi), 64'h4000_0000);
    run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0, 1'b0);
    check("div_neg_lo", 64'(o_lo), 64'hFFFF_FFFD);
    run_op("divu_100_7", 3'b011, 32'd100, 32'd7, 0, 0, 1'b0);
    check("divu_100_7_lo", 64'(o_lo), 64'd14);
    run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);
    check("div_ovf_lo", 64'(o_lo), 64'h8000_0000);
    run_op("divu_zero", 3'b011, 32'd5, 32'd0, 0, 0, 1'b0);
    check("divu_zero_hi", 64'(o_hi), 64'd5);
    run_op("div_zero", 3'b010, 32'hFFFF_FFF0, 32'd0, 0, 0, 1'b0);
    check("div_zero_hi", 64'(o_hi), 64'hFFFF_FFF0);

    run_op("multu_stall", 3'b001, 32'd1000, 32'd1000, 12, 10, 1'b1);
    check("multu_stall_lo", 64'(o_lo), 64'h000F_4240);

    i_start   = 1'b1;
    i_op      = 3'b100;
    i_rs_data = 32'h55;
    tick();
    check("mthi_55", 64'(o_hi), 64'h55);
    check("mthi_busy", 64'(o_busy), 64'd0);
    i_op = 3'b101;
    tick();
    check("mtlo_55", 64'(o_lo), 64'h55);
    check("mtlo_done", 64'(o_done), 64'd0);
    i_op      = 3'b011;
    i_rs_data = 32'd1000;
    i_rt_data = 32'd3;
    tick();
    i_start = 1'b0;
    repeat (15) tick();
    check("abort_busy_before", 64'(o_busy), 64'd1);
    i_reset = 1'b0;
    i_step  = 1'b0;
    tick();
    check("abort_busy", 64'(o_busy), 64'd0);
    check("abort_hilo", {o_hi, o_lo}, 64'd0);
    check("abort_done", 64'(o_done), 64'd0);
    i_reset   = 1'b1;
    i_step    = 1'b1;
    i_start   = 1'b1;
    i_op      = 3'b100;
    i_rs_data = 32'h1234;
    tick();
    i_start = 1'b0;
    check("mthi_1234", 64'(o_hi), 64'h1234);
    check("mthi_1234_busy", 64'(o_busy), 64'd0);
    tick();
    check("mthi_1234_idle", 64'(o_busy), 64'd0);

    for (int n = 0; n < 40; n++) begin
      rop  = 3'($urandom_range(0, 7));
      ra   = pick_operand();
      rb   = pick_operand();
      prev = {o_hi, o_lo};
      if (rop < 3'd4) begin
        run_op($sformatf("rand%0d_op%0d", n, rop), rop, ra, rb, 0, 0, 1'b0);
      end else begin
        i_start   = 1'b1;
        i_op      = rop;
        i_rs_data = ra;
        i_rt_data = rb;
        tick();
        i_start = 1'b0;
        if (rop == 3'd4)      prev[63:32] = ra;
        else if (rop == 3'd5) prev[31:0]  = ra;
        check($sformatf("rand%0d_mt_hilo", n), {o_hi, o_lo}, prev);
        check($sformatf("rand%0d_mt_busy", n), 64'({o_busy, o_done}), 64'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
